stopwatch_count_ctrl: RTL and testbench
=======================================

// Module: stopwatch_count_ctrl
// PURPOSE
//   Sequences the stopwatch time registers: SS.CC (seconds 0-59 left, centiseconds 0-99 right).
//   Sits between the stopwatch mode FSM and the display mux.
//   Run/edit/unit select come from the mode FSM; inc/dec/clear come from the input distributor.
//   Counts while running, applies per-unit edits while paused, and auto-repeats held edit keys.
// PARAMETERS
//   TICK_DIV    1_000_000  clk cycles per centisecond tick (100 MHz -> 100 Hz)
//   REPEAT_DLY  50_000_000 cycles a key is held after its first step before auto-repeat starts
//   REPEAT_PER  10_000_000 cycles between auto-repeat steps
// PORTS
//   iClk       in   1   system clock
//   iRst       in   1   asynchronous, active-high reset
//   iRun       in   1   count enable level from mode FSM
//   iEditEn    in   1   edit mode level from mode FSM
//   iEditUnit  in   1   0 = edit left (seconds), 1 = edit right (centiseconds)
//   iInc       in   1   debounced increment key level
//   iDec       in   1   debounced decrement key level
//   iClear     in   1   single-cycle clear command
//   oLeft      out  7   seconds, binary 0-59
//   oRight     out  7   centiseconds, binary 0-99
//   oBcd       out  16  {L10,L1,R10,R1} BCD of oLeft/oRight, combinational from registers
//   oTick      out  1   1-cycle pulse on each prescaler terminal count (RUN only)
//   oWrap      out  1   1-cycle pulse when the run count rolls 59.99 -> 00.00
// BEHAVIOUR
// - Reset (async, iRst=1)
//   - oLeft, oRight, oTick and oWrap are 0; oBcd = 16'h0000.
//   - Prescaler, repeat counter and key history are cleared.
//   - State is STOP. Reset asserted mid-count or mid-repeat aborts immediately.
// - States, re-evaluated every clock
//   - EDIT when iEditEn=1. EDIT wins over iRun if both are high.
//   - Else RUN when iRun=1.
//   - Else STOP.
// - Clear priority
//   - iClear=1 in any state zeroes oLeft, oRight and the prescaler next cycle.
//   - It also suppresses that cycle's tick and edit step.
// - Prescaler (0..TICK_DIV-1)
//   - Increments only in RUN. Holds its value in STOP/EDIT, so resume keeps the fractional tick.
//   - At TICK_DIV-1 it reloads 0, pulses oTick, and advances the time in the same edge.
// - Run count
//   - oRight+1. When oRight=99: oRight=0 and oLeft+1.
//   - When oLeft=59 and oRight=99: both go to 0 and oWrap pulses with oTick.
// - Edit (EDIT only; inc/dec keys are ignored in RUN and STOP)
//   - A step touches only the selected unit and wraps within it, with no carry.
//   - Left: 59+1 -> 0, 0-1 -> 59. Right: 99+1 -> 0, 0-1 -> 99.
//   - Step on key rising edge: register updates on the edge after the edge-detect cycle (1-cycle latency).
//   - Held key: the next step comes REPEAT_DLY cycles after the first step, then one every REPEAT_PER cycles.
//   - Key release, leaving EDIT, or an iEditUnit change resets the repeat counter. No step on release.
//   - iInc and iDec both high: no step, and the repeat counter is held at 0.
//   - A rising edge on one key while the other is released behaves as a fresh press.
// - Outputs are registered except oBcd.
//   - oLeft/oRight never leave the legal ranges.
// TESTING (sim params: TICK_DIV=4, REPEAT_DLY=20, REPEAT_PER=5)
//   1. Release iRst, iRun=1 for 40 clk -> oTick every 4th clk; oRight = 10; oLeft = 0; oBcd = 16'h0010.
//   2. Preload 59.98, run 8 clk -> oRight 99 then 00.00; oWrap and oTick high the same cycle.
//   3. iEditEn=1, iEditUnit=0, oLeft=59, pulse iInc 1 clk -> oLeft=0, oRight unchanged; iDec pulse -> oLeft=59.
//   4. EDIT, unit 1, hold iInc 36 clk from oRight=0 -> steps at +1, +21, +26, +31, +36 clk; oRight=5.
//   5. EDIT, hold iInc and iDec together 30 clk -> no change; iRun=1 and iEditEn=1 -> no ticks.
//   6. Run to 03.07, drop iRun 10 clk, resume -> next tick keeps prescaler phase; mid-run iClear -> 00.00 next clk.
//      Then assert iRst mid-repeat -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/stopwatch_count_ctrl_if.sv
// Connection bundle between the stopwatch mode FSM / input distributor side
// and the time-register sequencer. The master drives the control levels and
// key inputs; the slave (the sequencer) drives the time and pulse outputs.
interface stopwatch_count_ctrl_if;
    logic        iRun;
    logic        iEditEn;
    logic        iEditUnit;
    logic        iInc;
    logic        iDec;
    logic        iClear;
    logic [6:0]  oLeft;
    logic [6:0]  oRight;
    logic [15:0] oBcd;
    logic        oTick;
    logic        oWrap;

    modport master (
        output iRun,
        output iEditEn,
        output iEditUnit,
        output iInc,
        output iDec,
        output iClear,
        input  oLeft,
        input  oRight,
        input  oBcd,
        input  oTick,
        input  oWrap
    );

    modport slave (
        input  iRun,
        input  iEditEn,
        input  iEditUnit,
        input  iInc,
        input  iDec,
        input  iClear,
        output oLeft,
        output oRight,
        output oBcd,
        output oTick,
        output oWrap
    );
endinterface

// File: rtl/stopwatch_count_ctrl.sv
// Stopwatch time-register sequencer. Holds SS.CC (seconds 0-59 on the left,
// centiseconds 0-99 on the right), counts them from a centisecond prescaler
// while running, applies single-unit wrap-around edits while paused, and
// auto-repeats a held edit key. Mode decisions for each edge are taken from the
// state being entered on that edge, so a new iRun/iEditEn level acts at once.
module stopwatch_count_ctrl #(
    parameter int TICK_DIV   = 1_000_000,
    parameter int REPEAT_DLY = 50_000_000,
    parameter int REPEAT_PER = 10_000_000
) (
    input  logic                  iClk,
    input  logic                  iRst,
    stopwatch_count_ctrl_if.slave bus
);

    localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DLY - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PER - 1);

    localparam logic [6:0] LEFT_MAX  = 7'd59;
    localparam logic [6:0] RIGHT_MAX = 7'd99;

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_EDIT
    } state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic [6:0]       r_left;
    logic [6:0]       r_right;
    logic [PRE_W-1:0] r_pre;
    logic             r_tick;
    logic             r_wrap;

    logic             r_incQ;
    logic             r_incPrev;
    logic             r_decQ;
    logic             r_decPrev;
    logic             r_unitPrev;

    logic [RPT_W-1:0] r_rptCnt;
    logic             r_rptArmed;
    logic             r_rptActive;

    logic [6:0]       w_left;
    logic [6:0]       w_right;
    logic [PRE_W-1:0] w_pre;
    logic             w_tick;
    logic             w_wrap;

    logic [RPT_W-1:0] w_rptCnt;
    logic             w_rptArmed;
    logic             w_rptActive;
    logic             w_step;

    logic             w_singleKey;
    logic             w_freshPress;
    logic             w_unitChanged;
    logic [RPT_W-1:0] w_rptLimit;

    // Binary 0-99 to two BCD digits; the largest decade not above the value
    // gives the tens digit and the remainder the ones digit.
    function automatic logic [7:0] bin2bcd(input logic [6:0] value);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'd0;
        ones = value[3:0];
        for (int k = 1; k < 10; k++) begin
            if (value >= 7'(10 * k)) begin
                tens = 4'(k);
                ones = 4'(value - 7'(10 * k));
            end
        end
        return {tens, ones};
    endfunction

    // Mode arbitration: edit beats run, anything else is stopped.
    always_comb begin
        w_nextState = ST_STOP;
        if (bus.iEditEn) begin
            w_nextState = ST_EDIT;
        end else if (bus.iRun) begin
            w_nextState = ST_RUN;
        end
    end

    // Mode state register; a reset drops straight back to STOP.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Key history: one register stage, then the previous value, so a press is
    // seen as a rising edge one cycle after it arrives.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_incQ     <= 1'b0;
            r_incPrev  <= 1'b0;
            r_decQ     <= 1'b0;
            r_decPrev  <= 1'b0;
            r_unitPrev <= 1'b0;
        end else begin
            r_incQ     <= bus.iInc;
            r_incPrev  <= r_incQ;
            r_decQ     <= bus.iDec;
            r_decPrev  <= r_decQ;
            r_unitPrev <= bus.iEditUnit;
        end
    end

    // Exactly one key held is the only situation that can step; a fresh press
    // is that key rising while the other one stays released.
    assign w_singleKey   = r_incQ ^ r_decQ;
    assign w_freshPress  = (r_incQ & ~r_incPrev & ~r_decQ) |
                           (r_decQ & ~r_decPrev & ~r_incQ);
    assign w_unitChanged = (r_state == ST_EDIT) && (bus.iEditUnit != r_unitPrev);
    assign w_rptLimit    = r_rptArmed ? PER_LAST : DLY_LAST;

    // Edit step and auto-repeat decision. The first repeat waits the long delay,
    // later ones the short period; any disturbance restarts the wait.
    always_comb begin
        w_step      = 1'b0;
        w_rptCnt    = r_rptCnt;
        w_rptArmed  = r_rptArmed;
        w_rptActive = r_rptActive;
        if ((w_nextState != ST_EDIT) || !w_singleKey) begin
            w_rptCnt    = '0;
            w_rptArmed  = 1'b0;
            w_rptActive = 1'b0;
        end else if (w_freshPress) begin
            w_step      = 1'b1;
            w_rptCnt    = '0;
            w_rptArmed  = 1'b0;
            w_rptActive = 1'b1;
        end else if (w_unitChanged) begin
            w_rptCnt    = '0;
            w_rptArmed  = 1'b0;
        end else if (r_rptActive) begin
            if (r_rptCnt == w_rptLimit) begin
                w_step     = 1'b1;
                w_rptCnt   = '0;
                w_rptArmed = 1'b1;
            end else begin
                w_rptCnt = r_rptCnt + 1'b1;
            end
        end
    end

    // Repeat tracking registers.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_rptCnt    <= '0;
            r_rptArmed  <= 1'b0;
            r_rptActive <= 1'b0;
        end else begin
            r_rptCnt    <= w_rptCnt;
            r_rptArmed  <= w_rptArmed;
            r_rptActive <= w_rptActive;
        end
    end

    // Time datapath: clear wins, then run counting with carry and wrap, then a
    // carry-free edit of the selected unit. The prescaler only moves in RUN so
    // a pause keeps the fractional centisecond.
    always_comb begin
        w_left  = r_left;
        w_right = r_right;
        w_pre   = r_pre;
        w_tick  = 1'b0;
        w_wrap  = 1'b0;
        if (bus.iClear) begin
            w_left  = 7'd0;
            w_right = 7'd0;
            w_pre   = '0;
        end else begin
            case (w_nextState)
                ST_RUN: begin
                    if (r_pre == PRE_LAST) begin
                        w_pre  = '0;
                        w_tick = 1'b1;
                        if (r_right == RIGHT_MAX) begin
                            w_right = 7'd0;
                            if (r_left == LEFT_MAX) begin
                                w_left = 7'd0;
                                w_wrap = 1'b1;
                            end else begin
                                w_left = r_left + 7'd1;
                            end
                        end else begin
                            w_right = r_right + 7'd1;
                        end
                    end else begin
                        w_pre = r_pre + 1'b1;
                    end
                end
                ST_EDIT: begin
                    if (w_step) begin
                        if (!bus.iEditUnit) begin
                            if (r_incQ) begin
                                w_left = (r_left == LEFT_MAX) ? 7'd0 : r_left + 7'd1;
                            end else begin
                                w_left = (r_left == 7'd0) ? LEFT_MAX : r_left - 7'd1;
                            end
                        end else begin
                            if (r_incQ) begin
                                w_right = (r_right == RIGHT_MAX) ? 7'd0 : r_right + 7'd1;
                            end else begin
                                w_right = (r_right == 7'd0) ? RIGHT_MAX : r_right - 7'd1;
                            end
                        end
                    end
                end
                default: begin
                    w_pre = r_pre;
                end
            endcase
        end
    end

    // Time registers and the registered tick/wrap pulses.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_left  <= 7'd0;
            r_right <= 7'd0;
            r_pre   <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_left  <= w_left;
            r_right <= w_right;
            r_pre   <= w_pre;
            r_tick  <= w_tick;
            r_wrap  <= w_wrap;
        end
    end

    assign bus.oLeft  = r_left;
    assign bus.oRight = r_right;
    assign bus.oTick  = r_tick;
    assign bus.oWrap  = r_wrap;
    assign bus.oBcd   = {bin2bcd(r_left), bin2bcd(r_right)};

endmodule

// File: tb/tb_stopwatch_count_ctrl.sv
// Directed bench for the stopwatch time-register sequencer, using small
// prescaler and repeat constants so every scenario fits in a few hundred clocks.
module tb_stopwatch_count_ctrl;

    localparam int TICK_DIV   = 4;
    localparam int REPEAT_DLY = 20;
    localparam int REPEAT_PER = 5;

    logic iClk = 1'b0;
    logic iRst = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;

    stopwatch_count_ctrl_if swIf ();

    stopwatch_count_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (swIf)
    );

    // Free-running 10 ns clock.
    always #5 iClk = ~iClk;

    // Guard against a run that never reaches its summary.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance n clocks, leaving time 1 ns past the last rising edge.
    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iClk);
            #1;
        end
    endtask

    // One-clock key pulse followed by two quiet clocks; the step lands on the
    // second edge.
    task automatic applyStimulus(input logic inc, input logic dec);
        swIf.iInc = inc;
        swIf.iDec = dec;
        cycle(1);
        swIf.iInc = 1'b0;
        swIf.iDec = 1'b0;
        cycle(2);
    endtask

    // Pulse reset with all controls idle.
    task automatic applyReset;
        swIf.iRun      = 1'b0;
        swIf.iEditEn   = 1'b0;
        swIf.iEditUnit = 1'b0;
        swIf.iInc      = 1'b0;
        swIf.iDec      = 1'b0;
        swIf.iClear    = 1'b0;
        iRst = 1'b1;
        cycle(2);
        iRst = 1'b0;
    endtask

    task automatic test_reset;
        swIf.iRun = 1'b0; swIf.iEditEn = 1'b0; swIf.iEditUnit = 1'b0;
        swIf.iInc = 1'b0; swIf.iDec = 1'b0; swIf.iClear = 1'b0;
        #2 iRst = 1'b1;
        #1;
        compared++;
        if (swIf.oLeft !== 7'd0 || swIf.oRight !== 7'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_time: got %0d.%0d expected 0.0", swIf.oLeft, swIf.oRight);
        end
        compared++;
        if (swIf.oTick !== 1'b0 || swIf.oWrap !== 1'b0 || swIf.oBcd !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got tick=%b wrap=%b bcd=%h expected 0 0 0000",
                     swIf.oTick, swIf.oWrap, swIf.oBcd);
        end
        swIf.iRun = 1'b1;
        cycle(6);
        compared++;
        if (swIf.oRight !== 7'd0 || swIf.oTick !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_hold: got right=%0d tick=%b expected 0 0", swIf.oRight, swIf.oTick);
        end
        swIf.iRun = 1'b0;
        iRst = 1'b0;
        cycle(1);
    endtask

    task automatic test_run_count;
        applyReset();
        swIf.iRun = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            cycle(1);
            compared++;
            if (swIf.oTick !== ((k % 4) == 0)) begin
                mismatched++;
                $display("[TB] FAIL run_tick_%0d: got %b expected %b", k, swIf.oTick, ((k % 4) == 0));
            end
        end
        compared++;
        if (swIf.oLeft !== 7'd0 || swIf.oRight !== 7'd10) begin
            mismatched++;
            $display("[TB] FAIL run_time: got %0d.%0d expected 0.10", swIf.oLeft, swIf.oRight);
        end
        compared++;
        if (swIf.oBcd !== 16'h0010) begin
            mismatched++;
            $display("[TB] FAIL run_bcd: got %h expected 0010", swIf.oBcd);
        end
        swIf.iRun = 1'b0;
    endtask

    task automatic test_wrap;
        applyReset();
        swIf.iEditEn = 1'b1;
        swIf.iEditUnit = 1'b0;
        cycle(1);
        applyStimulus(1'b0, 1'b1);
        swIf.iEditUnit = 1'b1;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        compared++;
        if (swIf.oBcd !== 16'h5998) begin
            mismatched++;
            $display("[TB] FAIL wrap_preload: got %h expected 5998", swIf.oBcd);
        end
        swIf.iEditEn = 1'b0;
        swIf.iRun = 1'b1;
        cycle(4);
        compared++;
        if (swIf.oLeft !== 7'd59 || swIf.oRight !== 7'd99 || swIf.oTick !== 1'b1 || swIf.oWrap !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL wrap_5999: got %0d.%0d tick=%b wrap=%b expected 59.99 1 0",
                     swIf.oLeft, swIf.oRight, swIf.oTick, swIf.oWrap);
        end
        cycle(4);
        compared++;
        if (swIf.oLeft !== 7'd0 || swIf.oRight !== 7'd0 || swIf.oTick !== 1'b1 || swIf.oWrap !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL wrap_rollover: got %0d.%0d tick=%b wrap=%b expected 0.0 1 1",
                     swIf.oLeft, swIf.oRight, swIf.oTick, swIf.oWrap);
        end
        cycle(1);
        compared++;
        if (swIf.oWrap !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL wrap_pulse_len: got %b expected 0", swIf.oWrap);
        end
        swIf.iRun = 1'b0;
    endtask

    task automatic test_edit_wrap;
        applyReset();
        swIf.iEditEn = 1'b1;
        swIf.iEditUnit = 1'b0;
        cycle(1);
        applyStimulus(1'b0, 1'b1);
        compared++;
        if (swIf.oLeft !== 7'd59) begin
            mismatched++;
            $display("[TB] FAIL edit_left_dec0: got %0d expected 59", swIf.oLeft);
        end
        swIf.iEditUnit = 1'b1;
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0);
        swIf.iEditUnit = 1'b0;
        applyStimulus(1'b1, 1'b0);
        compared++;
        if (swIf.oLeft !== 7'd0 || swIf.oRight !== 7'd3) begin
            mismatched++;
            $display("[TB] FAIL edit_left_inc59: got %0d.%0d expected 0.3", swIf.oLeft, swIf.oRight);
        end
        applyStimulus(1'b0, 1'b1);
        compared++;
        if (swIf.oBcd !== 16'h5903) begin
            mismatched++;
            $display("[TB] FAIL edit_left_dec: got %h expected 5903", swIf.oBcd);
        end
        swIf.iEditUnit = 1'b1;
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1);
        compared++;
        if (swIf.oLeft !== 7'd59 || swIf.oRight !== 7'd99) begin
            mismatched++;
            $display("[TB] FAIL edit_right_dec0: got %0d.%0d expected 59.99", swIf.oLeft, swIf.oRight);
        end
        applyStimulus(1'b1, 1'b0);
        compared++;
        if (swIf.oLeft !== 7'd59 || swIf.oRight !== 7'd0) begin
            mismatched++;
            $display("[TB] FAIL edit_right_inc99: got %0d.%0d expected 59.0", swIf.oLeft, swIf.oRight);
        end
        swIf.iEditEn = 1'b0;
    endtask

    task automatic test_repeat;
        applyReset();
        swIf.iEditEn = 1'b1;
        swIf.iEditUnit = 1'b1;
        cycle(1);
        swIf.iInc = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            cycle(1);
            if (k == 2) begin
                compared++;
                if (swIf.oRight !== 7'd1) begin
                    mismatched++;
                    $display("[TB] FAIL repeat_first: got %0d expected 1", swIf.oRight);
                end
            end
            if (k == 21) begin
                compared++;
                if (swIf.oRight !== 7'd1) begin
                    mismatched++;
                    $display("[TB] FAIL repeat_delay: got %0d expected 1", swIf.oRight);
                end
            end
            if (k == 22) begin
                compared++;
                if (swIf.oRight !== 7'd2) begin
                    mismatched++;
                    $display("[TB] FAIL repeat_second: got %0d expected 2", swIf.oRight);
                end
            end
            if (k == 27) begin
                compared++;
                if (swIf.oRight !== 7'd3) begin
                    mismatched++;
                    $display("[TB] FAIL repeat_period: got %0d expected 3", swIf.oRight);
                end
            end
        end
        swIf.iInc = 1'b0;
        cycle(1);
        compared++;
        if (swIf.oRight !== 7'd5) begin
            mismatched++;
            $display("[TB] FAIL repeat_last: got %0d expected 5", swIf.oRight);
        end
        cycle(10);
        compared++;
        if (swIf.oRight !== 7'd5 || swIf.oLeft !== 7'd0) begin
            mismatched++;
            $display("[TB] FAIL repeat_release: got %0d.%0d expected 0.5", swIf.oLeft, swIf.oRight);
        end
        swIf.iEditEn = 1'b0;
    endtask

    task automatic test_unit_change;
        applyReset();
        swIf.iEditEn = 1'b1;
        swIf.iEditUnit = 1'b1;
        cycle(1);
        swIf.iInc = 1'b1;
        cycle(10);
        swIf.iEditUnit = 1'b0;
        cycle(20);
        compared++;
        if (swIf.oLeft !== 7'd0 || swIf.oRight !== 7'd1) begin
            mismatched++;
            $display("[TB] FAIL unit_change_restart: got %0d.%0d expected 0.1", swIf.oLeft, swIf.oRight);
        end
        cycle(1);
        compared++;
        if (swIf.oLeft !== 7'd1 || swIf.oRight !== 7'd1) begin
            mismatched++;
            $display("[TB] FAIL unit_change_step: got %0d.%0d expected 1.1", swIf.oLeft, swIf.oRight);
        end
        swIf.iInc = 1'b0;
        swIf.iEditEn = 1'b0;
        cycle(2);
    endtask

    task automatic test_back_to_back;
        applyReset();
        swIf.iEditEn = 1'b1;
        swIf.iEditUnit = 1'b1;
        cycle(1);
        swIf.iInc = 1'b1; cycle(1);
        swIf.iInc = 1'b0; cycle(1);
        swIf.iInc = 1'b1; cycle(1);
        swIf.iInc = 1'b0; cycle(3);
        compared++;
        if (swIf.oRight !== 7'd2) begin
            mismatched++;
            $display("[TB] FAIL b2b_double_press: got %0d expected 2", swIf.oRight);
        end
        swIf.iInc = 1'b1; cycle(3);
        swIf.iInc = 1'b0; swIf.iDec = 1'b1; cycle(1);
        swIf.iDec = 1'b0; cycle(3);
        compared++;
        if (swIf.oRight !== 7'd2) begin
            mismatched++;
            $display("[TB] FAIL b2b_key_swap: got %0d expected 2", swIf.oRight);
        end
        swIf.iEditEn = 1'b0;
    endtask

    task automatic test_both_keys;
        applyReset();
        swIf.iEditEn = 1'b1;
        swIf.iEditUnit = 1'b1;
        cycle(1);
        swIf.iInc = 1'b1;
        swIf.iDec = 1'b1;
        cycle(30);
        swIf.iInc = 1'b0;
        swIf.iDec = 1'b0;
        cycle(3);
        compared++;
        if (swIf.oLeft !== 7'd0 || swIf.oRight !== 7'd0) begin
            mismatched++;
            $display("[TB] FAIL both_keys: got %0d.%0d expected 0.0", swIf.oLeft, swIf.oRight);
        end
        swIf.iEditEn = 1'b0;
        applyStimulus(1'b1, 1'b0);
        compared++;
        if (swIf.oRight !== 7'd0) begin
            mismatched++;
            $display("[TB] FAIL stop_ignores_key: got %0d expected 0", swIf.oRight);
        end
        swIf.iEditEn = 1'b1;
        swIf.iRun = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cycle(1);
            compared++;
            if (swIf.oTick !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL edit_over_run_%0d: got tick=%b expected 0", k, swIf.oTick);
            end
        end
        swIf.iEditEn = 1'b0;
        cycle(4);
        compared++;
        if (swIf.oRight !== 7'd1 || swIf.oTick !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL run_after_edit: got right=%0d tick=%b expected 1 1", swIf.oRight, swIf.oTick);
        end
        swIf.iRun = 1'b0;
    endtask

    task automatic test_pause_clear_reset;
        applyReset();
        swIf.iRun = 1'b1;
        cycle(1230);
        compared++;
        if (swIf.oBcd !== 16'h0307) begin
            mismatched++;
            $display("[TB] FAIL pause_reach_0307: got %h expected 0307", swIf.oBcd);
        end
        swIf.iRun = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cycle(1);
            compared++;
            if (swIf.oTick !== 1'b0 || swIf.oRight !== 7'd7) begin
                mismatched++;
                $display("[TB] FAIL pause_hold_%0d: got right=%0d tick=%b expected 7 0", k, swIf.oRight, swIf.oTick);
            end
        end
        swIf.iRun = 1'b1;
        cycle(1);
        compared++;
        if (swIf.oTick !== 1'b0 || swIf.oRight !== 7'd7) begin
            mismatched++;
            $display("[TB] FAIL resume_phase1: got right=%0d tick=%b expected 7 0", swIf.oRight, swIf.oTick);
        end
        cycle(1);
        compared++;
        if (swIf.oTick !== 1'b1 || swIf.oRight !== 7'd8) begin
            mismatched++;
            $display("[TB] FAIL resume_phase2: got right=%0d tick=%b expected 8 1", swIf.oRight, swIf.oTick);
        end
        cycle(3);
        swIf.iClear = 1'b1;
        cycle(1);
        swIf.iClear = 1'b0;
        compared++;
        if (swIf.oLeft !== 7'd0 || swIf.oRight !== 7'd0 || swIf.oTick !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL clear_wins: got %0d.%0d tick=%b expected 0.0 0", swIf.oLeft, swIf.oRight, swIf.oTick);
        end
        cycle(3);
        compared++;
        if (swIf.oRight !== 7'd0 || swIf.oTick !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL clear_prescaler_a: got right=%0d tick=%b expected 0 0", swIf.oRight, swIf.oTick);
        end
        cycle(1);
        compared++;
        if (swIf.oRight !== 7'd1 || swIf.oTick !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL clear_prescaler_b: got right=%0d tick=%b expected 1 1", swIf.oRight, swIf.oTick);
        end
        swIf.iRun = 1'b0;
        swIf.iEditEn = 1'b1;
        swIf.iEditUnit = 1'b1;
        swIf.iInc = 1'b1;
        cycle(5);
        compared++;
        if (swIf.oRight !== 7'd2) begin
            mismatched++;
            $display("[TB] FAIL midrepeat_step: got %0d expected 2", swIf.oRight);
        end
        #2 iRst = 1'b1;
        #1;
        compared++;
        if (swIf.oLeft !== 7'd0 || swIf.oRight !== 7'd0 || swIf.oTick !== 1'b0 ||
            swIf.oWrap !== 1'b0 || swIf.oBcd !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL async_reset: got %0d.%0d tick=%b wrap=%b bcd=%h expected all 0",
                     swIf.oLeft, swIf.oRight, swIf.oTick, swIf.oWrap, swIf.oBcd);
        end
        swIf.iInc = 1'b0;
        cycle(2);
        iRst = 1'b0;
        cycle(30);
        compared++;
        if (swIf.oRight !== 7'd0) begin
            mismatched++;
            $display("[TB] FAIL post_reset_quiet: got %0d expected 0", swIf.oRight);
        end
        swIf.iEditEn = 1'b0;
    endtask

    // Scenario sequence followed by the one summary line.
    initial begin
        $display("[TB] start");
        test_reset();
        test_run_count();
        test_wrap();
        test_edit_wrap();
        test_repeat();
        test_unit_change();
        test_back_to_back();
        test_both_keys();
        test_pause_clear_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
